register_access_sequencer: RTL

//  Initiator side of the 8x8 data register file: accepts one decoded instruction (rd, ra, rb, wb),

---
 rtl/register_access_sequencer_pkg.sv | 17 +
 rtl/register_access_sequencer_if.sv | 53 +++++
 rtl/register_access_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/register_access_sequencer_pkg.sv
// Shared types and default widths for the register access sequencer.
// Holds the FSM state encoding used by the sequencer and its bench.
package register_access_sequencer_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/register_access_sequencer_if.sv
// Decoder / register-file / execute-unit signals seen by the sequencer.
// master = sequencer side, slave = environment (decoder, regfile, ALU).
interface register_access_sequencer_if #(
  parameter int unsigned DATA_W = register_access_sequencer_pkg::DATA_W,
  parameter int unsigned ADDR_W = register_access_sequencer_pkg::ADDR_W,
  parameter int unsigned CNT_W  = register_access_sequencer_pkg::CNT_W
);

  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] instr_ra;
  logic [ADDR_W-1:0] instr_rb;
  logic [ADDR_W-1:0] instr_rd;
  logic              instr_wb;

  logic              Enable_Read_Data_A;
  logic              Enable_Read_Data_B;
  logic [ADDR_W-1:0] Data_A_address;
  logic [ADDR_W-1:0] Data_B_address;
  logic [DATA_W-1:0] Data_out_A;
  logic [DATA_W-1:0] Data_out_B;
  logic              Enable_write;
  logic [DATA_W-1:0] Data_write;
  logic [ADDR_W-1:0] Data_write_address;

  logic              op_valid;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;

  logic              err_timeout;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    input  instr_valid, instr_ra, instr_rb, instr_rd, instr_wb,
    input  Data_out_A, Data_out_B, res_valid, res_data,
    output instr_ready, Enable_Read_Data_A, Enable_Read_Data_B,
    output Data_A_address, Data_B_address,
    output Enable_write, Data_write, Data_write_address,
    output op_valid, op_a, op_b, err_timeout, retired_cnt
  );

  modport slave (
    output instr_valid, instr_ra, instr_rb, instr_rd, instr_wb,
    output Data_out_A, Data_out_B, res_valid, res_data,
    input  instr_ready, Enable_Read_Data_A, Enable_Read_Data_B,
    input  Data_A_address, Data_B_address,
    input  Enable_write, Data_write, Data_write_address,
    input  op_valid, op_a, op_b, err_timeout, retired_cnt
  );

endinterface

// File: rtl/register_access_sequencer.sv
// Sequences one instruction: read both operands, wait for the execute result,
// then optionally write it back. Every output is a register.
module register_access_sequencer #(
  parameter int unsigned DATA_W  = register_access_sequencer_pkg::DATA_W,
  parameter int unsigned ADDR_W  = register_access_sequencer_pkg::ADDR_W,
  parameter int unsigned TIMEOUT = register_access_sequencer_pkg::TIMEOUT,
  parameter int unsigned CNT_W   = register_access_sequencer_pkg::CNT_W
) (
  input logic                          clk,
  input logic                          rst_n,
  register_access_sequencer_if.master  bus
);

  import register_access_sequencer_pkg::*;

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_q, rd_nxt;
  logic              wb_q, wb_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;

  logic              ready_q, ready_nxt;
  logic              rd_en_q, rd_en_nxt;
  logic [ADDR_W-1:0] addr_a_q, addr_a_nxt;
  logic [ADDR_W-1:0] addr_b_q, addr_b_nxt;
  logic              we_q, we_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [ADDR_W-1:0] waddr_q, waddr_nxt;
  logic              op_valid_q, op_valid_nxt;
  logic [DATA_W-1:0] op_a_q, op_a_nxt;
  logic [DATA_W-1:0] op_b_q, op_b_nxt;
  logic              err_q, err_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_q       <= '0;
      wb_q       <= 1'b0;
      wait_q     <= '0;
      ready_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      rd_q       <= rd_nxt;
      wb_q       <= wb_nxt;
      wait_q     <= wait_nxt;
      ready_q    <= ready_nxt;
      rd_en_q    <= rd_en_nxt;
      addr_a_q   <= addr_a_nxt;
      addr_b_q   <= addr_b_nxt;
      we_q       <= we_nxt;
      wdata_q    <= wdata_nxt;
      waddr_q    <= waddr_nxt;
      op_valid_q <= op_valid_nxt;
      op_a_q     <= op_a_nxt;
      op_b_q     <= op_b_nxt;
      err_q      <= err_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  // Outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_nxt    = state;
    rd_nxt       = rd_q;
    wb_nxt       = wb_q;
    wait_nxt     = wait_q;
    rd_en_nxt    = 1'b0;
    addr_a_nxt   = '0;
    addr_b_nxt   = '0;
    we_nxt       = 1'b0;
    wdata_nxt    = '0;
    waddr_nxt    = '0;
    op_valid_nxt = 1'b0;
    op_a_nxt     = op_a_q;
    op_b_nxt     = op_b_q;
    err_nxt      = 1'b0;
    cnt_nxt      = cnt_q;

    case (state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_nxt  = S_READ;
          rd_nxt     = bus.instr_rd;
          wb_nxt     = bus.instr_wb;
          rd_en_nxt  = 1'b1;
          addr_a_nxt = bus.instr_ra;
          addr_b_nxt = bus.instr_rb;
        end
      end
      S_READ: begin
        state_nxt    = S_EXEC;
        op_a_nxt     = bus.Data_out_A;
        op_b_nxt     = bus.Data_out_B;
        op_valid_nxt = 1'b1;
        wait_nxt     = '0;
      end
      S_EXEC: begin
        // A result arriving on the final wait cycle still beats the timeout.
        if (bus.res_valid) begin
          if (wb_q) begin
            state_nxt = S_WRITE;
            we_nxt    = 1'b1;
            wdata_nxt = bus.res_data;
            waddr_nxt = rd_q;
          end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = cnt_q + CNT_W'(1);
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt     = wait_q + WAIT_W'(1);
          op_valid_nxt = 1'b1;
        end
      end
      S_WRITE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = cnt_q + CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = (state_nxt == S_IDLE);
  end

  assign bus.instr_ready        = ready_q;
  assign bus.Enable_Read_Data_A = rd_en_q;
  assign bus.Enable_Read_Data_B = rd_en_q;
  assign bus.Data_A_address     = addr_a_q;
  assign bus.Data_B_address     = addr_b_q;
  assign bus.Enable_write       = we_q;
  assign bus.Data_write         = wdata_q;
  assign bus.Data_write_address = waddr_q;
  assign bus.op_valid           = op_valid_q;
  assign bus.op_a               = op_a_q;
  assign bus.op_b               = op_b_q;
  assign bus.err_timeout        = err_q;
  assign bus.retired_cnt        = cnt_q;

endmodule
